// File: rtl/sbl_pkg.sv
// -----------------------------------------------------------------------------
// sbl_pkg
// Shared types and constants for the serial byte loader.
//   sbl_state_t : loader FSM state encoding
//   WORD_RST    : reset value of the downstream 8-bit register stage
// -----------------------------------------------------------------------------
package sbl_pkg;

    typedef enum logic [2:0] {
        S_IDLE,
        S_SHIFT,
        S_PARITY,
        S_WRITE,
        S_DONE
    } sbl_state_t;

    localparam logic [7:0] WORD_RST = 8'hFF;

endpackage

// File: rtl/serial_byte_loader_shift.sv
// -----------------------------------------------------------------------------
// shift_in_reg
// Serial-in shift register that holds the word being assembled.
//   clk  : clock, rising edge
//   rst  : synchronous active-high reset, clears the word to 0
//   en   : shift sin in this cycle
//   sin  : serial data bit
//   word : assembled word
// With LSB_FIRST=1 bits enter at the top and move down, so the first bit of a
// WIDTH-bit frame ends up in word[0]; with LSB_FIRST=0 bits enter at the bottom
// and the first bit ends up in word[WIDTH-1].
// -----------------------------------------------------------------------------
module shift_in_reg #(
    parameter int WIDTH     = 8,
    parameter bit LSB_FIRST = 1'b1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             sin,
    output logic [WIDTH-1:0] word
);

    always_ff @(posedge clk) begin
        if (rst) begin
            word <= '0;
        end else if (en) begin
            if (LSB_FIRST) begin
                word <= {sin, word[WIDTH-1:1]};
            end else begin
                word <= {word[WIDTH-2:0], sin};
            end
        end
    end

endmodule

// File: rtl/serial_byte_loader.sv
// -----------------------------------------------------------------------------
// serial_byte_loader
// Assembles a serial bit stream into a WIDTH-bit word, optionally checks an
// even-parity bit, and presents the word with a one-cycle write strobe to a
// downstream write-enabled register. Words that fail parity are never written.
//   clk       : clock, rising edge
//   rst       : synchronous active-high reset, priority over all inputs
//   start     : begin a frame (sampled only in IDLE)
//   sin       : serial data bit
//   sin_valid : sin is consumed this cycle (SHIFT / PARITY only)
//   d_out     : last good word (reset: all ones) -> register D
//   wr        : one-cycle write strobe -> register wr
//   busy      : high in every state except IDLE
//   done      : one-cycle pulse at the end of every frame, good or bad
//   par_err   : sticky parity error, cleared by the next accepted start
// Handshake: a bit is transferred on every rising edge where the FSM is in
// SHIFT or PARITY and sin_valid=1; sin_valid=0 simply stalls the frame.
// All outputs are registers; sin never reaches wr combinationally.
// -----------------------------------------------------------------------------
module serial_byte_loader
    import sbl_pkg::*;
#(
    parameter int WIDTH     = 8,
    parameter bit LSB_FIRST = 1'b1,
    parameter bit PARITY_EN = 1'b1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             sin,
    input  logic             sin_valid,
    output logic [WIDTH-1:0] d_out,
    output logic             wr,
    output logic             busy,
    output logic             done,
    output logic             par_err
);

    localparam int                CNT_W    = $clog2(WIDTH + 1);
    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);

    sbl_state_t       state;
    logic [CNT_W-1:0] bit_cnt;
    logic [WIDTH-1:0] word;
    logic [WIDTH-1:0] word_next;
    logic             shift_en;

    assign shift_en = (state == S_SHIFT) && sin_valid;

    shift_in_reg #(
        .WIDTH     (WIDTH),
        .LSB_FIRST (LSB_FIRST)
    ) u_shift (
        .clk  (clk),
        .rst  (rst),
        .en   (shift_en),
        .sin  (sin),
        .word (word)
    );

    // Without a parity bit, d_out must be loaded on the same edge that shifts
    // in the last data bit, so the word including that bit is formed here.
    always_comb begin
        word_next = word;
        if (LSB_FIRST) begin
            word_next = {sin, word[WIDTH-1:1]};
        end else begin
            word_next = {word[WIDTH-2:0], sin};
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= S_IDLE;
            bit_cnt <= '0;
            d_out   <= '1;
            wr      <= 1'b0;
            busy    <= 1'b0;
            done    <= 1'b0;
            par_err <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    wr   <= 1'b0;
                    done <= 1'b0;
                    // A sin_valid seen together with start is not captured:
                    // shifting is only enabled in S_SHIFT.
                    if (start) begin
                        state   <= S_SHIFT;
                        bit_cnt <= '0;
                        par_err <= 1'b0;
                        busy    <= 1'b1;
                    end
                end

                S_SHIFT: begin
                    if (sin_valid) begin
                        bit_cnt <= bit_cnt + CNT_W'(1);
                        if (bit_cnt == LAST_BIT) begin
                            if (PARITY_EN) begin
                                state <= S_PARITY;
                            end else begin
                                state <= S_WRITE;
                                d_out <= word_next;
                                wr    <= 1'b1;
                            end
                        end
                    end
                end

                S_PARITY: begin
                    if (sin_valid) begin
                        // Even parity: the parity bit equals the XOR of the data.
                        if (sin == ^word) begin
                            state <= S_WRITE;
                            d_out <= word;
                            wr    <= 1'b1;
                        end else begin
                            state   <= S_DONE;
                            par_err <= 1'b1;
                            done    <= 1'b1;
                        end
                    end
                end

                S_WRITE: begin
                    state <= S_DONE;
                    wr    <= 1'b0;
                    done  <= 1'b1;
                end

                S_DONE: begin
                    // start in this cycle is ignored; it is re-sampled in IDLE.
                    state <= S_IDLE;
                    done  <= 1'b0;
                    busy  <= 1'b0;
                end

                default: begin
                    state <= S_IDLE;
                    wr    <= 1'b0;
                    done  <= 1'b0;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_serial_byte_loader.sv
// -----------------------------------------------------------------------------
// tb_serial_byte_loader
// Self-checking bench for serial_byte_loader. Two instances share clock/reset:
//   dut   : default build (WIDTH=8, LSB first, even parity enabled)
//   dut_m : MSB-first build without parity
// Frames are described by data byte + parity bit; the reference model decides
// from the parity rule whether a write must happen and what d_out must hold.
// -----------------------------------------------------------------------------
module tb_serial_byte_loader;
    import sbl_pkg::*;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst;
    logic       start, sin, sin_valid;
    logic [7:0] d_out;
    logic       wr, busy, done, par_err;

    logic       start_m, sin_m, sin_valid_m;
    logic [7:0] d_out_m;
    logic       wr_m, busy_m, done_m, par_err_m;

    serial_byte_loader #(.WIDTH(8), .LSB_FIRST(1'b1), .PARITY_EN(1'b1)) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .sin       (sin),
        .sin_valid (sin_valid),
        .d_out     (d_out),
        .wr        (wr),
        .busy      (busy),
        .done      (done),
        .par_err   (par_err)
    );

    serial_byte_loader #(.WIDTH(8), .LSB_FIRST(1'b0), .PARITY_EN(1'b0)) dut_m (
        .clk       (clk),
        .rst       (rst),
        .start     (start_m),
        .sin       (sin_m),
        .sin_valid (sin_valid_m),
        .d_out     (d_out_m),
        .wr        (wr_m),
        .busy      (busy_m),
        .done      (done_m),
        .par_err   (par_err_m)
    );

    // ---------------- scoreboard state ----------------
    int         n_checks = 0;
    int         n_errors = 0;
    logic [7:0] exp_q[$];
    logic [7:0] model_d   = 8'hFF;   // word the register stage should hold
    logic [7:0] model_m   = 8'hFF;
    bit         mon_en    = 1'b0;
    logic       prev_wr   = 1'b0;
    int         wr_seen   = 0;
    int         wr_expect = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Monitor: every write must match the oldest expected word, last exactly
    // one cycle, and d_out must hold the model word whenever wr is low.
    always @(negedge clk) begin
        if (mon_en) begin
            if (wr) begin
                wr_seen++;
                check("wr_one_cycle", prev_wr, 1'b0);
                check("wr_expected", exp_q.size() != 0, 1'b1);
                if (exp_q.size() != 0) check("wr_data", d_out, exp_q.pop_front());
            end else begin
                check("d_out_hold", d_out, model_d);
            end
            prev_wr = wr;
        end
    end

    // ---------------- driver tasks ----------------
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic int stall_count(input int mode);
        if (mode == 1) return 1;
        if (mode == 2) return $urandom_range(0, 3);
        return 0;
    endfunction

    // One LSB-first frame on dut: 8 data bits then the given parity bit.
    // mode: 0 no stalls, 1 stall before every bit, 2 random stalls.
    task automatic send_frame(input logic [7:0] data, input logic par,
                              input int mode, input logic start_on_done);
        logic good;
        good = (par == ^data);
        start     = 1'b1;
        sin_valid = 1'($urandom_range(0, 1));   // must not be captured
        sin       = 1'($urandom_range(0, 1));
        step();
        start = 1'b0;
        check("busy_after_start", busy, 1'b1);
        check("par_err_cleared", par_err, 1'b0);
        for (int i = 0; i < 9; i++) begin
            repeat (stall_count(mode)) begin
                sin_valid = 1'b0;
                sin       = 1'($urandom_range(0, 1));
                start     = 1'($urandom_range(0, 1));
                step();
                check("busy_stall", busy, 1'b1);
                check("wr_quiet", wr, 1'b0);
            end
            if (i == 8 && good) begin
                exp_q.push_back(data);
                wr_expect++;
            end
            sin_valid = 1'b1;
            sin       = (i < 8) ? data[i] : par;
            start     = 1'($urandom_range(0, 1));
            step();
        end
        sin_valid = 1'b0;
        start     = 1'($urandom_range(0, 1));
        if (good) begin
            model_d = data;
            check("wr_pulse", wr, 1'b1);
            check("d_out_new", d_out, data);
            check("done_early", done, 1'b0);
            step();
        end else begin
            check("wr_bad_frame", wr, 1'b0);
        end
        check("done_pulse", done, 1'b1);
        check("wr_after", wr, 1'b0);
        check("par_err", par_err, !good);
        check("busy_in_done", busy, 1'b1);
        start = start_on_done;
        step();
        start = 1'b0;
        check("busy_idle", busy, 1'b0);
        check("done_clear", done, 1'b0);
        check("d_out_final", d_out, model_d);
        step();
        check("start_on_done_ignored", busy, 1'b0);
        check("par_err_sticky", par_err, !good);
    endtask

    // Frame aborted by reset after four data bits.
    task automatic reset_mid_frame();
        start = 1'b1;
        step();
        start = 1'b0;
        for (int i = 0; i < 4; i++) begin
            sin_valid = 1'b1;
            sin       = 1'($urandom_range(0, 1));
            step();
        end
        rst       = 1'b1;
        sin_valid = 1'b1;
        start     = 1'b1;
        step();
        model_d   = WORD_RST;
        model_m   = WORD_RST;
        rst       = 1'b0;
        sin_valid = 1'b0;
        start     = 1'b0;
        check("rst_mid_d_out", d_out, WORD_RST);
        check("rst_mid_busy", busy, 1'b0);
        check("rst_mid_wr", wr, 1'b0);
        check("rst_mid_done", done, 1'b0);
        step();
        check("rst_mid_idle", busy, 1'b0);
    endtask

    // One MSB-first frame on dut_m, no parity bit.
    task automatic send_frame_m(input logic [7:0] data, input int mode);
        start_m     = 1'b1;
        sin_valid_m = 1'b1;
        sin_m       = ~data[7];               // must not be captured
        step();
        start_m = 1'b0;
        check("m_busy_after_start", busy_m, 1'b1);
        for (int i = 7; i >= 0; i--) begin
            repeat (stall_count(mode)) begin
                sin_valid_m = 1'b0;
                sin_m       = 1'($urandom_range(0, 1));
                start_m     = 1'($urandom_range(0, 1));
                step();
                check("m_wr_quiet", wr_m, 1'b0);
            end
            sin_valid_m = 1'b1;
            sin_m       = data[i];
            step();
            if (i == 4) check("m_d_out_hold", d_out_m, model_m);
        end
        sin_valid_m = 1'b0;
        start_m     = 1'b1;
        model_m     = data;
        check("m_wr_pulse", wr_m, 1'b1);
        check("m_d_out", d_out_m, data);
        step();
        check("m_done", done_m, 1'b1);
        check("m_wr_after", wr_m, 1'b0);
        step();
        start_m = 1'b0;
        check("m_busy_idle", busy_m, 1'b0);
        check("m_par_err", par_err_m, 1'b0);
        step();
        check("m_idle_stays", busy_m, 1'b0);
        check("m_d_out_final", d_out_m, model_m);
    endtask

    // ---------------- stimulus ----------------
    initial begin
        logic [7:0] data;
        logic       bad;

        rst = 1'b1; start = 1'b0; sin = 1'b0; sin_valid = 1'b0;
        start_m = 1'b0; sin_m = 1'b0; sin_valid_m = 1'b0;
        repeat (2) step();
        check("rst_d_out", d_out, WORD_RST);
        check("rst_wr", wr, 1'b0);
        check("rst_busy", busy, 1'b0);
        check("rst_done", done, 1'b0);
        check("rst_par_err", par_err, 1'b0);
        check("m_rst_d_out", d_out_m, WORD_RST);
        rst    = 1'b0;
        mon_en = 1'b1;
        step();

        send_frame(8'hA5, 1'b0, 0, 1'b0);   // good frame
        send_frame(8'h3C, 1'b1, 0, 1'b0);   // wrong parity, d_out keeps A5
        send_frame(8'h81, 1'b0, 1, 1'b0);   // alternating stalls
        reset_mid_frame();
        send_frame(8'h0F, 1'b0, 0, 1'b0);
        send_frame(8'h5A, 1'b0, 2, 1'b1);   // start during busy and with done

        send_frame_m(8'h81, 0);
        send_frame_m(8'hC4, 1);

        for (int n = 0; n < 40; n++) begin
            data = 8'($urandom_range(0, 255));
            bad  = ($urandom_range(0, 3) == 0);
            send_frame(data, (^data) ^ bad, $urandom_range(0, 2), 1'($urandom_range(0, 1)));
        end
        for (int n = 0; n < 10; n++) begin
            send_frame_m(8'($urandom_range(0, 255)), $urandom_range(0, 2));
        end

        step();
        check("wr_count", wr_seen, wr_expect);
        check("exp_q_drained", exp_q.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1, "watchdog expired");
    end

endmodule
